// File: rtl/vls_pkg.sv
// Shared types and default sizing for the vector load/store engine.
package vls_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } vls_state_e;

  localparam int VLS_LANES  = 16;
  localparam int VLS_W      = 16;
  localparam int VLS_AW     = 16;
  localparam int VLS_RD_LAT = 1;

  // Width of a lane index; never zero so a single-lane build still has a port.
  function automatic int lane_bits(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/vls_addr_gen.sv
// Picks the lowest remaining enabled lane and forms its wrapped address
// plus a flag telling whether the exact address fell outside the memory.
module vls_addr_gen
  import vls_pkg::*;
#(
  parameter int LANES = VLS_LANES,
  parameter int AW    = VLS_AW,
  parameter int LW    = lane_bits(VLS_LANES)
) (
  input  logic [LANES-1:0] rem_mask,
  input  logic [AW-1:0]    base,
  input  logic [AW-1:0]    stride,
  output logic             any,
  output logic [LW-1:0]    lane,
  output logic [LANES-1:0] rem_next,
  output logic [AW-1:0]    addr,
  output logic             wrap
);

  // Wide enough that base + lane*stride never overflows in the signed domain.
  localparam int EW = AW + LW + 2;

  logic signed [EW-1:0] base_x;
  logic signed [EW-1:0] idx_x;
  logic signed [EW-1:0] stride_x;
  logic signed [EW-1:0] exact;

  always_comb begin
    any  = 1'b0;
    lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (rem_mask[i]) begin
        any  = 1'b1;
        lane = LW'(i);
      end
    end
    rem_next = rem_mask;
    if (any) rem_next[lane] = 1'b0;
  end

  always_comb begin
    base_x   = {{(EW-AW){1'b0}}, base};
    idx_x    = {{(EW-LW){1'b0}}, lane};
    stride_x = {{(EW-AW){stride[AW-1]}}, stride};
    exact    = base_x + idx_x * stride_x;
    addr     = exact[AW-1:0];
    wrap     = any && (exact[EW-1:AW] != '0);
  end

endmodule

// File: rtl/vls_engine.sv
// Strided, masked vector load/store engine: one memory access per enabled
// lane per cycle, load data merged into a lane buffer after RD_LAT cycles.
module vls_engine
  import vls_pkg::*;
#(
  parameter int LANES  = VLS_LANES,
  parameter int W      = VLS_W,
  parameter int AW     = VLS_AW,
  parameter int RD_LAT = VLS_RD_LAT
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic               IsStore,
  input  logic [AW-1:0]      Base,
  input  logic [AW-1:0]      Stride,
  input  logic [LANES-1:0]   Mask,
  input  logic [LANES*W-1:0] VecIn,
  input  logic [W-1:0]       DataIn,
  output logic [AW-1:0]      Addr,
  output logic               RD,
  output logic               WR,
  output logic [W-1:0]       DataOut,
  output logic [LANES*W-1:0] VecOut,
  output logic               VecWE,
  output logic               Busy,
  output logic               Done,
  output logic               AddrErr,
  output vls_state_e         dbg_state
);

  localparam int LW = lane_bits(LANES);

  vls_state_e         state_q, state_d;
  logic               is_store_q, is_store_d;
  logic [AW-1:0]      base_q, base_d;
  logic [AW-1:0]      stride_q, stride_d;
  logic [LANES-1:0]   rem_q, rem_d;
  logic [LANES*W-1:0] vec_q, vec_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               vecwe_q, vecwe_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [RD_LAT-1:0]  pv_q, pv_d;
  logic [LW-1:0]      pl_q [RD_LAT];
  logic [LW-1:0]      pl_d [RD_LAT];

  logic               ag_any;
  logic [LW-1:0]      ag_lane;
  logic [LANES-1:0]   ag_rem_next;
  logic [AW-1:0]      ag_addr;
  logic               ag_wrap;
  logic               issue;

  vls_addr_gen #(.LANES(LANES), .AW(AW), .LW(LW)) u_addr_gen (
    .rem_mask (rem_q),
    .base     (base_q),
    .stride   (stride_q),
    .any      (ag_any),
    .lane     (ag_lane),
    .rem_next (ag_rem_next),
    .addr     (ag_addr),
    .wrap     (ag_wrap)
  );

  assign issue     = (state_q == ST_ISSUE) && ag_any;
  assign RD        = issue && !is_store_q;
  assign WR        = issue && is_store_q;
  assign Addr      = issue ? ag_addr : '0;
  assign DataOut   = WR ? vec_q[int'(ag_lane)*W +: W] : '0;
  assign VecOut    = vec_q;
  assign VecWE     = vecwe_q;
  assign Done      = done_q;
  assign Busy      = (state_q != ST_IDLE);
  assign AddrErr   = err_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    base_d     = base_q;
    stride_d   = stride_q;
    rem_d      = rem_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    vecwe_d    = 1'b0;
    vec_d      = vec_q;

    // Read-return pipeline: stage j holds the lane of a read issued j+1 cycles ago.
    pv_d[0] = RD;
    pl_d[0] = ag_lane;
    for (int j = 1; j < RD_LAT; j++) begin
      pv_d[j] = pv_q[j-1];
      pl_d[j] = pl_q[j-1];
    end
    if (pv_q[RD_LAT-1]) vec_d[int'(pl_q[RD_LAT-1])*W +: W] = DataIn;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          is_store_d = IsStore;
          base_d     = Base;
          stride_d   = Stride;
          rem_d      = Mask;
          vec_d      = VecIn;
          err_d      = 1'b0;
          if (Mask == '0) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        rem_d = ag_rem_next;
        err_d = err_q | ag_wrap;
        if (ag_rem_next == '0) begin
          if (is_store_q) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = ST_DRAIN;
            cnt_d   = 2'(RD_LAT - 1);
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
          vecwe_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      is_store_q <= 1'b0;
      base_q     <= '0;
      stride_q   <= '0;
      rem_q      <= '0;
      vec_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      vecwe_q    <= 1'b0;
      cnt_q      <= '0;
      pv_q       <= '0;
      pl_q       <= '{default: '0};
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      base_q     <= base_d;
      stride_q   <= stride_d;
      rem_q      <= rem_d;
      vec_q      <= vec_d;
      err_q      <= err_d;
      done_q     <= done_d;
      vecwe_q    <= vecwe_d;
      cnt_q      <= cnt_d;
      pv_q       <= pv_d;
      pl_q       <= pl_d;
    end
  end

endmodule

// File: tb/tb_vls_engine.sv
// Bench for vls_engine: a memory model with RD_LAT read latency, an
// operation-level reference model, directed corner cases and random traffic.
module tb_vls_engine;
  import vls_pkg::*;

  localparam int LANES  = 16;
  localparam int W      = 16;
  localparam int AW     = 16;
  localparam int RD_LAT = 2;
  localparam int VW     = LANES * W;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          Start = 1'b0;
  logic          IsStore = 1'b0;
  logic [AW-1:0] Base = '0;
  logic [AW-1:0] Stride = '0;
  logic [LANES-1:0] Mask = '0;
  logic [VW-1:0] VecIn = '0;
  logic [W-1:0]  DataIn = '0;
  logic [AW-1:0] Addr;
  logic          RD, WR;
  logic [W-1:0]  DataOut;
  logic [VW-1:0] VecOut;
  logic          VecWE, Busy, Done, AddrErr;
  vls_state_e    dbg_state;

  vls_engine #(.LANES(LANES), .W(W), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .IsStore(IsStore),
    .Base(Base), .Stride(Stride), .Mask(Mask), .VecIn(VecIn), .DataIn(DataIn),
    .Addr(Addr), .RD(RD), .WR(WR), .DataOut(DataOut), .VecOut(VecOut),
    .VecWE(VecWE), .Busy(Busy), .Done(Done), .AddrErr(AddrErr),
    .dbg_state(dbg_state)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] mem [1<<AW];

  // Scoreboard: expected access stream and completion for one operation.
  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            exp_cyc_q[$];
  int            exp_done, exp_vecwe;
  logic [VW-1:0] exp_vec;
  logic          exp_err;

  logic [W-1:0]  obs_q[$];
  logic [AW-1:0] obs_addr_q[$];
  int            obs_cyc_q[$];
  int            obs_wrong_kind, obs_both, obs_busy_bad;
  int            obs_done_cyc, obs_vecwe_cyc, obs_vecwe_cnt;
  logic [VW-1:0] obs_vec;
  logic          obs_err;

  // Memory responder: read data for an RD seen in cycle n is presented in cycle n+RD_LAT.
  initial begin : mem_resp
    logic          hv [RD_LAT];
    logic [AW-1:0] ha [RD_LAT];
    logic          r;
    logic [AW-1:0] a;
    for (int j = 0; j < RD_LAT; j++) begin hv[j] = 1'b0; ha[j] = '0; end
    forever begin
      @(negedge Clk);
      r = RD;
      a = Addr;
      @(posedge Clk);
      #1;
      for (int j = RD_LAT - 1; j > 0; j--) begin hv[j] = hv[j-1]; ha[j] = ha[j-1]; end
      hv[0] = r;
      ha[0] = a;
      DataIn = hv[RD_LAT-1] ? mem[ha[RD_LAT-1]] : W'($urandom);
    end
  end

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  // Reference model: lane i address is base + i*stride, exact integer arithmetic.
  task automatic model_op(input logic st, input logic [AW-1:0] b, input logic [AW-1:0] s,
                          input logic [LANES-1:0] m, input logic [VW-1:0] v);
    int k;
    longint e;
    logic [AW-1:0] a;
    k = 0;
    exp_q.delete(); exp_addr_q.delete(); exp_cyc_q.delete();
    exp_vec = v;
    exp_err = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (m[i]) begin
        e = longint'(b) + longint'(i) * longint'($signed(s));
        a = AW'(e);
        if (e < 0 || e >= (longint'(1) << AW)) exp_err = 1'b1;
        k++;
        exp_addr_q.push_back(a);
        exp_cyc_q.push_back(k);
        if (st) begin
          exp_q.push_back(v[i*W +: W]);
          mem[a] = v[i*W +: W];
        end else begin
          exp_q.push_back(mem[a]);
          exp_vec[i*W +: W] = mem[a];
        end
      end
    end
    exp_done  = (k == 0) ? 1 : (st ? k + 1 : k + RD_LAT + 1);
    exp_vecwe = (!st && k > 0) ? exp_done : -1;
  endtask

  // Driver + monitor for one operation; optional extra Start at cycle bs_cyc while busy.
  task automatic run_op(input logic st, input logic [AW-1:0] b, input logic [AW-1:0] s,
                        input logic [LANES-1:0] m, input logic [VW-1:0] v, input int bs_cyc);
    int c;
    obs_q.delete(); obs_addr_q.delete(); obs_cyc_q.delete();
    obs_wrong_kind = 0; obs_both = 0; obs_busy_bad = 0;
    obs_done_cyc = -1; obs_vecwe_cyc = -1; obs_vecwe_cnt = 0;
    obs_vec = '0; obs_err = 1'b0;
    @(posedge Clk); #1;
    Start = 1'b1; IsStore = st; Base = b; Stride = s; Mask = m; VecIn = v;
    @(posedge Clk); #1;
    Start = 1'b0; IsStore = 1'($urandom); Base = AW'($urandom);
    Mask = LANES'($urandom); VecIn = rand_vec();
    c = 1;
    while (c < 200) begin
      if (Busy !== 1'b1) obs_busy_bad++;
      if (RD === 1'b1 && WR === 1'b1) obs_both++;
      if (RD === 1'b1 || WR === 1'b1) begin
        if (WR !== st || RD !== ~st) obs_wrong_kind++;
        obs_addr_q.push_back(Addr);
        obs_q.push_back(DataOut);
        obs_cyc_q.push_back(c);
      end
      if (VecWE === 1'b1) begin
        obs_vecwe_cnt++;
        obs_vecwe_cyc = c;
        obs_vec = VecOut;
      end
      if (Done === 1'b1) begin
        obs_done_cyc = c;
        obs_err = AddrErr;
        break;
      end
      if (c == bs_cyc) begin
        Start = 1'b1; IsStore = ~st; Base = AW'($urandom); Stride = AW'($urandom);
        Mask = '1; VecIn = rand_vec();
      end
      @(posedge Clk); #1;
      Start = 1'b0;
      c++;
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if ({Addr, RD, WR, DataOut, VecOut, VecWE, Busy, Done, AddrErr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %0h required 0", {Addr, RD, WR, DataOut, VecOut, VecWE, Busy, Done, AddrErr});
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_store_linear();
    logic [VW-1:0] v;
    v = rand_vec();
    model_op(1'b1, 16'h0100, 16'h0001, 16'hFFFF, v);
    run_op(1'b1, 16'h0100, 16'h0001, 16'hFFFF, v, 0);
    checks++;
    if (obs_addr_q.size() != 16) begin
      failures++;
      $display("FAIL store_linear_count: got %0d required 16", obs_addr_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (obs_addr_q[i] !== AW'(16'h0100 + i) || obs_cyc_q[i] != i + 1 || obs_q[i] !== v[i*W +: W]) begin
          failures++;
          $display("FAIL store_linear_wr%0d: got addr %0h cyc %0d data %0h required addr %0h cyc %0d data %0h",
                   i, obs_addr_q[i], obs_cyc_q[i], obs_q[i], 16'h0100 + i, i + 1, v[i*W +: W]);
        end
      end
    end
    checks++;
    if (obs_done_cyc != 17 || obs_err !== 1'b0) begin
      failures++;
      $display("FAIL store_linear_done: got cyc %0d err %0b required cyc 17 err 0", obs_done_cyc, obs_err);
    end
    checks++;
    if (obs_busy_bad != 0 || obs_both != 0 || obs_wrong_kind != 0 || obs_vecwe_cnt != 0) begin
      failures++;
      $display("FAIL store_linear_proto: got busy_bad %0d both %0d kind %0d vecwe %0d required all 0",
               obs_busy_bad, obs_both, obs_wrong_kind, obs_vecwe_cnt);
    end
  endtask

  task automatic test_load_neg_stride();
    logic [VW-1:0] v;
    v = rand_vec();
    model_op(1'b0, 16'h0020, 16'hFFFE, 16'h0005, v);
    run_op(1'b0, 16'h0020, 16'hFFFE, 16'h0005, v, 0);
    checks++;
    if (obs_addr_q.size() != 2 || obs_addr_q[0] !== 16'h0020 || obs_addr_q[1] !== 16'h001C
        || obs_cyc_q[0] != 1 || obs_cyc_q[1] != 2 || obs_wrong_kind != 0) begin
      failures++;
      $display("FAIL load_neg_rd: got %0d reads first %0h required 2 reads at 20,1c", obs_addr_q.size(),
               (obs_addr_q.size() > 0) ? obs_addr_q[0] : 16'hxxxx);
    end
    checks++;
    if (obs_done_cyc != 5 || obs_vecwe_cyc != 5 || obs_vecwe_cnt != 1) begin
      failures++;
      $display("FAIL load_neg_done: got done %0d vecwe %0d required 5 5", obs_done_cyc, obs_vecwe_cyc);
    end
    checks++;
    if (obs_vec !== exp_vec || obs_err !== 1'b0) begin
      failures++;
      $display("FAIL load_neg_vec: got %0h err %0b required %0h err 0", obs_vec, obs_err, exp_vec);
    end
  endtask

  task automatic test_load_wrap();
    logic [VW-1:0] v;
    v = rand_vec();
    model_op(1'b0, 16'hFFFE, 16'h0001, 16'h000F, v);
    run_op(1'b0, 16'hFFFE, 16'h0001, 16'h000F, v, 0);
    checks++;
    if (obs_addr_q.size() != 4 || obs_addr_q[0] !== 16'hFFFE || obs_addr_q[1] !== 16'hFFFF
        || obs_addr_q[2] !== 16'h0000 || obs_addr_q[3] !== 16'h0001) begin
      failures++;
      $display("FAIL load_wrap_addr: got %0d reads required fffe,ffff,0000,0001", obs_addr_q.size());
    end
    checks++;
    if (obs_err !== 1'b1 || obs_done_cyc != 4 + RD_LAT + 1) begin
      failures++;
      $display("FAIL load_wrap_err: got err %0b done %0d required err 1 done %0d", obs_err, obs_done_cyc, 4 + RD_LAT + 1);
    end
    checks++;
    if (obs_vec !== exp_vec) begin
      failures++;
      $display("FAIL load_wrap_vec: got %0h required %0h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_zero_mask();
    for (int mode = 0; mode < 2; mode++) begin
      run_op(1'(mode), AW'($urandom), AW'($urandom), '0, rand_vec(), 0);
      checks++;
      if (obs_addr_q.size() != 0 || obs_vecwe_cnt != 0 || obs_done_cyc != 1 || obs_busy_bad != 0) begin
        failures++;
        $display("FAIL zero_mask_mode%0d: got strobes %0d vecwe %0d done %0d required 0 0 1",
                 mode, obs_addr_q.size(), obs_vecwe_cnt, obs_done_cyc);
      end
    end
  endtask

  task automatic test_start_busy();
    logic [VW-1:0] v;
    int bad;
    v = rand_vec();
    model_op(1'b1, 16'h4000, 16'h0003, 16'h0F0F, v);
    run_op(1'b1, 16'h4000, 16'h0003, 16'h0F0F, v, 3);
    checks++;
    if (obs_addr_q.size() != exp_addr_q.size() || obs_done_cyc != exp_done || obs_wrong_kind != 0) begin
      failures++;
      $display("FAIL busy_start_op: got %0d writes done %0d required %0d writes done %0d",
               obs_addr_q.size(), obs_done_cyc, exp_addr_q.size(), exp_done);
    end else begin
      for (int i = 0; i < exp_addr_q.size(); i++) begin
        checks++;
        if (obs_addr_q[i] !== exp_addr_q[i] || obs_q[i] !== exp_q[i] || obs_cyc_q[i] != exp_cyc_q[i]) begin
          failures++;
          $display("FAIL busy_start_wr%0d: got %0h/%0h required %0h/%0h", i, obs_addr_q[i], obs_q[i], exp_addr_q[i], exp_q[i]);
        end
      end
    end
    // Start raised in the Done cycle itself must also be dropped.
    Start = 1'b1; IsStore = 1'b1; Mask = '1;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge Clk); #1;
      Start = 1'b0;
      if (Busy !== 1'b0 || RD !== 1'b0 || WR !== 1'b0 || Done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL start_in_done_cycle: got %0d active cycles required 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] v;
    for (int n = 0; n < 3; n++) begin
      v = rand_vec();
      model_op(1'(n % 2), AW'(16'h1000 * n), AW'(n + 1), LANES'(16'h00F1 << n), v);
      run_op(1'(n % 2), AW'(16'h1000 * n), AW'(n + 1), LANES'(16'h00F1 << n), v, 0);
      checks++;
      if (obs_done_cyc != exp_done || obs_addr_q.size() != exp_addr_q.size()
          || (exp_vecwe >= 0 && obs_vec !== exp_vec)) begin
        failures++;
        $display("FAIL back_to_back%0d: got done %0d accesses %0d required done %0d accesses %0d",
                 n, obs_done_cyc, obs_addr_q.size(), exp_done, exp_addr_q.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    int act;
    @(posedge Clk); #1;
    Start = 1'b1; IsStore = 1'b0; Base = 16'h2000; Stride = 16'h0001; Mask = '1; VecIn = rand_vec();
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (2) begin @(posedge Clk); #1; end
    Reset_n = 1'b0;
    #1;
    checks++;
    if ({Addr, RD, WR, DataOut, VecOut, VecWE, Busy, Done, AddrErr} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got %0h required 0", {Addr, RD, WR, DataOut, VecOut, VecWE, Busy, Done, AddrErr});
    end
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    act = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge Clk); #1;
      if (RD !== 1'b0 || WR !== 1'b0 || VecWE !== 1'b0 || Done !== 1'b0 || Busy !== 1'b0) act++;
    end
    checks++;
    if (act != 0) begin
      failures++;
      $display("FAIL reset_mid_quiet: got %0d active cycles required 0", act);
    end
  endtask

  task automatic test_random();
    logic st;
    logic [AW-1:0] b, s;
    logic [LANES-1:0] m;
    logic [VW-1:0] v;
    for (int n = 0; n < 40; n++) begin
      st = 1'($urandom);
      b  = AW'($urandom);
      s  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($signed(4'($urandom_range(0, 15))));
      m  = ($urandom_range(0, 9) == 0) ? '0 : LANES'($urandom);
      v  = rand_vec();
      model_op(st, b, s, m, v);
      run_op(st, b, s, m, v, 0);
      checks++;
      if (obs_addr_q.size() != exp_addr_q.size()) begin
        failures++;
        $display("FAIL rand%0d_count: got %0d required %0d", n, obs_addr_q.size(), exp_addr_q.size());
      end else begin
        for (int i = 0; i < exp_addr_q.size(); i++) begin
          checks++;
          if (obs_addr_q[i] !== exp_addr_q[i] || obs_cyc_q[i] != exp_cyc_q[i] || (st && obs_q[i] !== exp_q[i])) begin
            failures++;
            $display("FAIL rand%0d_acc%0d: got addr %0h cyc %0d data %0h required addr %0h cyc %0d data %0h",
                     n, i, obs_addr_q[i], obs_cyc_q[i], obs_q[i], exp_addr_q[i], exp_cyc_q[i], exp_q[i]);
          end
        end
      end
      checks++;
      if (obs_done_cyc != exp_done || obs_err !== exp_err) begin
        failures++;
        $display("FAIL rand%0d_done: got cyc %0d err %0b required cyc %0d err %0b", n, obs_done_cyc, obs_err, exp_done, exp_err);
      end
      checks++;
      if (obs_vecwe_cnt != ((exp_vecwe < 0) ? 0 : 1)
          || (exp_vecwe >= 0 && (obs_vecwe_cyc != exp_vecwe || obs_vec !== exp_vec))) begin
        failures++;
        $display("FAIL rand%0d_vec: got n %0d cyc %0d vec %0h required cyc %0d vec %0h",
                 n, obs_vecwe_cnt, obs_vecwe_cyc, obs_vec, exp_vecwe, exp_vec);
      end
      checks++;
      if (obs_busy_bad != 0 || obs_both != 0 || obs_wrong_kind != 0) begin
        failures++;
        $display("FAIL rand%0d_proto: got busy_bad %0d both %0d kind %0d required 0 0 0",
                 n, obs_busy_bad, obs_both, obs_wrong_kind);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = W'($urandom);
    test_reset();
    test_store_linear();
    test_load_neg_stride();
    test_load_wrap();
    test_zero_mask();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
